filter_pipe_ctrl: RTL and testbench
===================================

FILTER_PIPE_CTRL -- requirements
Module: filter_pipe_ctrl

Interface
REQ-001 SHALL have parameter PIX_BIT, default 8, pixel width (informational, for companion datapath).
REQ-002 SHALL have parameter MASK_WIDTH, default 7, square mask side K.
REQ-003 SHALL have parameter IMG_W, default 640, pixels per row.
REQ-004 SHALL have parameter IMG_H, default 480, rows per frame.
REQ-005 SHALL have parameter PIPE_LAT, default 7, adder-tree latency in cycles, ≥1.
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port reset, input, 1, asynchronous active-low reset (0 = reset).
REQ-008 SHALL have port in_valid, input, 1, pixel present this cycle.
REQ-009 SHALL have port in_sof, input, 1, qualifies the first pixel of a frame.
REQ-010 SHALL have port in_ready, output, 1, controller accepts the pixel; transfer = in_valid & in_ready.
REQ-011 SHALL have port out_valid, output, 1, adder-tree output q valid this cycle.
REQ-012 SHALL have port out_sof, output, 1, first valid output of the frame.
REQ-013 SHALL have port out_eof, output, 1, last valid output of the frame.
REQ-014 SHALL have port out_border, output, 1, output position lies in the border region.
REQ-015 SHALL have port busy, output, 1, state ≠ IDLE or tokens in flight.
REQ-016 SHALL have port sof_err, output, 1, one-cycle pulse on an unexpected in_sof.

Function
REQ-017 SHALL implement FSM states IDLE, FILL, RUN, FLUSH.
REQ-018 IDLE: in_ready=1; a transfer with in_sof=1 → FILL, col=1, row=0; transfers without in_sof are dropped.
REQ-019 FILL: col increments per transfer and wraps IMG_W-1→0 with row+1; when row reaches K-1 → RUN.
REQ-020 RUN: same counting; a transfer at row=IMG_H-1, col=IMG_W-1 → FLUSH.
REQ-021 FLUSH: in_ready=0 for exactly PIPE_LAT cycles, then → IDLE.
REQ-022 An interior token SHALL be issued on any transfer at which, after counting, row≥K-1 and col≥K-1.
REQ-023 Tokens SHALL pass through a PIPE_LAT-deep shift register; out_valid SHALL equal the token issued PIPE_LAT cycles earlier.
REQ-024 out_sof and out_eof SHALL travel in the same shift register as their token, so output latency is exactly PIPE_LAT cycles.
REQ-025 Exactly one out_sof and one out_eof SHALL occur per completed frame.
REQ-026 In FILL or RUN, a transfer with in_sof=1 SHALL pulse sof_err, restart counting at row=0/col=1 in FILL, and leave in-flight tokens to drain unchanged.
REQ-027 in_valid=0 cycles SHALL freeze the counters while the shift register keeps advancing.
REQ-028 busy SHALL be 1 if state≠IDLE or any shift-register stage holds a token.

Reset
REQ-029 While reset=0, state SHALL be IDLE, counters and shift register 0, and in_ready=1; out_valid, out_sof, out_eof, out_border, busy, and sof_err SHALL be 0.
REQ-030 Reset asserted mid-frame SHALL discard all in-flight tokens immediately, with no out_eof produced.
REQ-031 Release SHALL be sampled on a clk edge; the first transfer is accepted on the first edge after release.

Configuration
REQ-032 Macro FILTER_BORDER_PASS_EN SHALL select border handling.
REQ-033 With FILTER_BORDER_PASS_EN defined: a token SHALL be issued on every transfer (IMG_W*IMG_H per frame). out_border=1 for positions with row<K-1 or col<K-1, referenced to the output pixel. out_sof marks pixel (0,0).
REQ-034 Without FILTER_BORDER_PASS_EN: tokens SHALL be issued only per REQ-022, giving (IMG_W-K+1)*(IMG_H-K+1) per frame, and out_border SHALL be tied 0.

Verification (bench config IMG_W=10, IMG_H=8, MASK_WIDTH=3, PIPE_LAT=4, in_valid continuous)
REQ-035 Full frame, macro off: exactly 48 out_valid pulses; first at 4 cycles after transfer #23 with out_sof=1; out_eof on the 48th; FLUSH holds in_ready=0 for 4 cycles.
REQ-036 Full frame, macro on: exactly 80 out_valid pulses; out_border=1 on 32 of them; out_sof on the first, out_eof on the 80th.
REQ-037 in_valid toggling 1/0 each cycle: output count and ordering identical to REQ-035, and every out_valid occurs exactly 4 cycles after its issuing transfer.
REQ-038 in_sof asserted at transfer #30: sof_err pulses once, and the frame restarts; a full subsequent 80-pixel frame yields 48 outputs, with no out_eof from the aborted frame.
REQ-039 reset=0 asserted for 1 cycle at transfer #50: all outputs go 0 asynchronously, no further out_valid occurs, and busy=0 after release.
REQ-040 Pixels without in_sof in IDLE: no tokens and busy=0; the next frame with in_sof behaves per REQ-035.

Source files
------------

// File: rtl/filter_pipe_ctrl.sv
// Frame-position controller for a KxK filter: issues tokens that ride a PIPE_LAT-deep shift register alongside the adder tree.
// Build option FILTER_BORDER_PASS_EN: emit a token for every pixel and flag border positions, instead of emitting interior pixels only.
module filter_pipe_ctrl #(
  parameter int PIX_BIT    = 8,
  parameter int MASK_WIDTH = 7,
  parameter int IMG_W      = 640,
  parameter int IMG_H      = 480,
  parameter int PIPE_LAT   = 7
) (
  input  logic clk,
  input  logic reset,
  input  logic in_valid,
  input  logic in_sof,
  output logic in_ready,
  output logic out_valid,
  output logic out_sof,
  output logic out_eof,
  output logic out_border,
  output logic busy,
  output logic sof_err
);
  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int FW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
  localparam logic [CW-1:0] LAST_COL   = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW   = RW'(IMG_H - 1);
  localparam logic [CW-1:0] EDGE_COL   = CW'(MASK_WIDTH - 1);
  localparam logic [RW-1:0] EDGE_ROW   = RW'(MASK_WIDTH - 1);
  localparam logic [FW-1:0] FLUSH_LAST = FW'(PIPE_LAT - 1);

  if (PIX_BIT < 1 || MASK_WIDTH < 1 || PIPE_LAT < 1 ||
      MASK_WIDTH > IMG_W || MASK_WIDTH > IMG_H) begin : g_param_check
    $error("filter_pipe_ctrl: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, FILL, RUN, FLUSH} state_t;
  typedef struct packed {
    logic valid;
    logic sof;
    logic eof;
    logic border;
  } tok_t;

  state_t          state_q;
  logic [RW-1:0]   row_q, row_d, pix_row;
  logic [CW-1:0]   col_q, col_d, pix_col;
  logic [FW-1:0]   flush_cnt_q;
  logic            in_ready_q, sof_err_q;
  logic            xfer, start, count, take, last_pix;
  tok_t            tok_d;
  tok_t            pipe_q [PIPE_LAT];

  // A start pixel is always (0,0), whether it opens a frame or restarts one.
  always_comb begin
    xfer     = in_valid & in_ready_q;
    start    = xfer & in_sof;
    count    = xfer & ~in_sof & (state_q == FILL || state_q == RUN);
    take     = start | count;
    pix_row  = start ? '0 : row_q;
    pix_col  = start ? '0 : col_q;
    last_pix = take & (pix_row == LAST_ROW) & (pix_col == LAST_COL);
    if (pix_col == LAST_COL) begin
      col_d = '0;
      row_d = pix_row + 1'b1;
    end else begin
      col_d = pix_col + 1'b1;
      row_d = pix_row;
    end
    tok_d = '0;
`ifdef FILTER_BORDER_PASS_EN
    tok_d.valid  = take;
    tok_d.sof    = start;
    tok_d.border = (pix_row < EDGE_ROW) | (pix_col < EDGE_COL);
`else
    tok_d.valid  = take & (pix_row >= EDGE_ROW) & (pix_col >= EDGE_COL);
    tok_d.sof    = (pix_row == EDGE_ROW) & (pix_col == EDGE_COL);
`endif
    tok_d.eof = last_pix;
    if (!tok_d.valid) tok_d = '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      row_q       <= '0;
      col_q       <= '0;
      flush_cnt_q <= '0;
      in_ready_q  <= 1'b1;
      sof_err_q   <= 1'b0;
    end else begin
      sof_err_q <= start & (state_q == FILL || state_q == RUN);
      if (take) begin
        row_q <= row_d;
        col_q <= col_d;
      end
      case (state_q)
        IDLE, FILL, RUN: begin
          if (last_pix) begin
            state_q     <= FLUSH;
            in_ready_q  <= 1'b0;
            flush_cnt_q <= '0;
          end else if (start) begin
            state_q <= FILL;
          end else if (count && state_q == FILL && row_d >= EDGE_ROW) begin
            state_q <= RUN;
          end
        end
        FLUSH: begin
          // Input stays blocked until the adder tree has drained the last token.
          if (flush_cnt_q == FLUSH_LAST) begin
            state_q    <= IDLE;
            in_ready_q <= 1'b1;
          end else begin
            flush_cnt_q <= flush_cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  for (genvar gi = 0; gi < PIPE_LAT; gi++) begin : g_pipe
    if (gi == 0) begin : g_head
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) pipe_q[gi] <= '0;
        else        pipe_q[gi] <= tok_d;
      end
    end else begin : g_tail
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) pipe_q[gi] <= '0;
        else        pipe_q[gi] <= pipe_q[gi-1];
      end
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
    for (int i = 0; i < PIPE_LAT; i++) busy = busy | pipe_q[i].valid;
  end

  assign in_ready   = in_ready_q;
  assign sof_err    = sof_err_q;
  assign out_valid  = pipe_q[PIPE_LAT-1].valid;
  assign out_sof    = pipe_q[PIPE_LAT-1].sof;
  assign out_eof    = pipe_q[PIPE_LAT-1].eof;
  assign out_border = pipe_q[PIPE_LAT-1].border;
endmodule

// File: tb/tb_filter_pipe_ctrl.sv
// Scenario table + scoreboard bench for filter_pipe_ctrl (10x8 frame, 3x3 mask, 4-cycle tree).
module tb_filter_pipe_ctrl;
  localparam int W = 10, H = 8, K = 3, L = 4, NS = 5;

  logic clk = 1'b0, reset = 1'b0, in_valid = 1'b0, in_sof = 1'b0;
  logic in_ready, out_valid, out_sof, out_eof, out_border, busy, sof_err;

  filter_pipe_ctrl #(.PIX_BIT(8), .MASK_WIDTH(K), .IMG_W(W), .IMG_H(H), .PIPE_LAT(L)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof),
    .in_ready(in_ready), .out_valid(out_valid), .out_sof(out_sof), .out_eof(out_eof),
    .out_border(out_border), .busy(busy), .sof_err(sof_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int due;
    bit sof;
    bit eof;
    bit border;
  } exp_t;

  typedef struct {
    int n_xfer;
    int toggle;
    int junk;
    int sof_at;
    int rst_at;
    int exp_out;
    int exp_sof;
    int exp_eof;
    int exp_border;
    int exp_err;
  } scen_t;

  exp_t  sbq[$];
  exp_t  mon_e;
  scen_t tbl [NS];
  int n_total = 0, n_pass = 0, cyc = 0;
  int n_out, n_sof, n_eof, n_bord, n_err;
  bit mon_en = 0;
  bit m_active = 0;
  int m_p = 0, m_flush = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference model of frame position: decides which pixels produce a token and when it is due.
  task automatic model_xfer(input bit s);
    int r, c;
    exp_t e;
    if (s) begin
      m_active = 1;
      m_p = 0;
    end else if (!m_active) begin
      return;
    end
    r = m_p / W;
    c = m_p % W;
    e.due = cyc + L;
    e.eof = (m_p == W * H - 1);
`ifdef FILTER_BORDER_PASS_EN
    e.sof = (m_p == 0);
    e.border = (r < K - 1) || (c < K - 1);
    sbq.push_back(e);
`else
    e.sof = (r == K - 1) && (c == K - 1);
    e.border = 0;
    if (r >= K - 1 && c >= K - 1) sbq.push_back(e);
`endif
    if (m_p == W * H - 1) begin
      m_active = 0;
      m_flush = L;
    end
    m_p++;
  endtask

  task automatic drive(input bit v, input bit s, output bit took);
    @(negedge clk);
    check("in_ready", in_ready, int'(m_flush == 0));
    if (m_flush > 0) m_flush--;
    in_valid = v;
    in_sof = s;
    took = v && in_ready;
    if (took) model_xfer(s);
  endtask

  task automatic do_reset();
    @(negedge clk);
    check("pre_rst_busy", busy, 1);
    in_valid = 1;
    in_sof = 0;
    #1 reset = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_eof", out_eof, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    sbq.delete();
    m_active = 0;
    m_flush = 0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    check("post_rst_busy", busy, 0);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sof_err) n_err++;
      if (out_valid) begin
        n_out++;
        n_sof += int'(out_sof);
        n_eof += int'(out_eof);
        n_bord += int'(out_border);
        if (sbq.size() == 0) begin
          check("unexpected_out_valid", out_valid, 0);
        end else begin
          mon_e = sbq.pop_front();
          check("out_cycle", cyc, mon_e.due);
          check("out_sof", out_sof, int'(mon_e.sof));
          check("out_eof", out_eof, int'(mon_e.eof));
          check("out_border", out_border, int'(mon_e.border));
        end
      end else if (sbq.size() > 0 && sbq[0].due <= cyc) begin
        check("out_valid_due", out_valid, 1);
        void'(sbq.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit v, s, took, junk_done;
    int t, ph, guard;
    scen_t sc;
    // {n_xfer, toggle, junk, sof_at, rst_at, out, sof, eof, border, sof_err}
`ifdef FILTER_BORDER_PASS_EN
    tbl[0] = '{80,  0, 0, -1, -1, 80,  1, 1, 32, 0};
    tbl[1] = '{80,  1, 0, -1, -1, 80,  1, 1, 32, 0};
    tbl[2] = '{109, 0, 0, 30, -1, 109, 2, 1, 54, 1};
    tbl[3] = '{80,  0, 0, -1, 50, 46,  1, 0, 26, 0};
    tbl[4] = '{85,  0, 5, -1, -1, 80,  1, 1, 32, 0};
`else
    tbl[0] = '{80,  0, 0, -1, -1, 48, 1, 1, 0, 0};
    tbl[1] = '{80,  1, 0, -1, -1, 48, 1, 1, 0, 0};
    tbl[2] = '{109, 0, 0, 30, -1, 55, 2, 1, 0, 1};
    tbl[3] = '{80,  0, 0, -1, 50, 20, 1, 0, 0, 0};
    tbl[4] = '{85,  0, 5, -1, -1, 48, 1, 1, 0, 0};
`endif

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_sof", out_sof, 0);
    check("reset_out_eof", out_eof, 0);
    check("reset_out_border", out_border, 0);
    check("reset_busy", busy, 0);
    check("reset_sof_err", sof_err, 0);
    reset = 1'b1;
    mon_en = 1;

    for (int si = 0; si < NS; si++) begin
      sc = tbl[si];
      n_out = 0; n_sof = 0; n_eof = 0; n_bord = 0; n_err = 0;
      t = 0; ph = 0; guard = 0; junk_done = 0;
      while (t < sc.n_xfer && guard < 1000) begin
        v = (sc.toggle != 0) ? (ph % 2 == 0) : 1'b1;
        ph++;
        guard++;
        if (v && t + 1 == sc.rst_at) begin
          do_reset();
          t++;
        end else begin
          s = v && ((t + 1 == sc.junk + 1) || (t + 1 == sc.sof_at));
          drive(v, s, took);
          if (took) t++;
        end
        if (sc.junk > 0 && t == sc.junk && !junk_done) begin
          junk_done = 1;
          @(posedge clk);
          #1 check("junk_busy", busy, 0);
        end
      end
      check("xfer_count", t, sc.n_xfer);
      guard = 0;
      while ((sbq.size() > 0 || busy || m_flush > 0) && guard < 40) begin
        drive(1'b0, 1'b0, took);
        guard++;
      end
      #1;
      check("drain_busy", busy, 0);
      check("drain_pending", sbq.size(), 0);
      check("n_out", n_out, sc.exp_out);
      check("n_out_sof", n_sof, sc.exp_sof);
      check("n_out_eof", n_eof, sc.exp_eof);
      check("n_out_border", n_bord, sc.exp_border);
      check("n_sof_err", n_err, sc.exp_err);
      $display("scenario %0d: %0d transfers, %0d outputs, %0d sof_err", si, t, n_out, n_err);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
